// File: rtl/mul_pkg.sv
// Shared definitions for the multiply start/done handshake, used by this
// responder and by the ALU-side sequencer.
package mul_pkg;
  localparam int WORD_SIZE = 8;
  localparam int CNT_SIZE  = $clog2(WORD_SIZE);
  localparam int LAST_CNT  = WORD_SIZE - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mul_state_t;
endpackage

// File: rtl/mul_add_shift_stage.sv
// One shift-add iteration: conditionally add the multiplicand into the high
// half, then shift {carry, acc_hi, acc_lo} right by one bit.
module mul_add_shift_stage #(
  parameter int word_size = 8
) (
  input  logic [word_size-1:0] acc_hi,
  input  logic [word_size-1:0] acc_lo,
  input  logic [word_size-1:0] mcand,
  output logic [word_size-1:0] acc_hi_nxt,
  output logic [word_size-1:0] acc_lo_nxt
);
  logic [word_size:0] sum;

  // The extra sum bit is the carry; it becomes the MSB after the shift.
  always_comb begin
    sum = {1'b0, acc_hi};
    if (acc_lo[0]) sum = {1'b0, acc_hi} + {1'b0, mcand};
    acc_hi_nxt = sum[word_size:1];
    acc_lo_nxt = {sum[0], acc_lo[word_size-1:1]};
  end
endmodule

// File: rtl/mul_seq_responder.sv
// Sequential shift-add unsigned multiplier: accepts a start pulse, iterates
// one bit per clock, and returns the product with a one-cycle mul_done.
module mul_seq_responder
  import mul_pkg::*;
#(
  parameter int word_size = WORD_SIZE,
  parameter int cnt_size  = CNT_SIZE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [word_size-1:0]   multiplicand,
  input  logic [word_size-1:0]   multiplier,
  output logic [2*word_size-1:0] product,
  output logic                   mul_done,
  output logic                   busy
);
  localparam logic [cnt_size-1:0] LAST = cnt_size'(word_size - 1);

  mul_state_t           state;
  logic [cnt_size-1:0]  cnt;
  logic [word_size-1:0] mcand_r, acc_hi, acc_lo;
  logic [word_size-1:0] acc_hi_nxt, acc_lo_nxt;

  mul_add_shift_stage #(.word_size(word_size)) u_stage (
    .acc_hi     (acc_hi),
    .acc_lo     (acc_lo),
    .mcand      (mcand_r),
    .acc_hi_nxt (acc_hi_nxt),
    .acc_lo_nxt (acc_lo_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      mcand_r  <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      product  <= '0;
      mul_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          mul_done <= 1'b0;
          if (start) begin
            mcand_r <= multiplicand;
            acc_hi  <= '0;
            acc_lo  <= multiplier;
            cnt     <= '0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_hi <= acc_hi_nxt;
          acc_lo <= acc_lo_nxt;
          cnt    <= cnt + 1'b1;
          // Fixed latency: no early exit, even for zero operands.
          if (cnt == LAST) begin
            product  <= {acc_hi_nxt, acc_lo_nxt};
            mul_done <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          mul_done <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          mul_done <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
endmodule

// File: tb/tb_mul_seq_responder.sv
// Self-checking bench for mul_seq_responder against a plain A*B model.
module tb_mul_seq_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  multiplicand, multiplier;
  logic [15:0] product;
  logic        mul_done, busy;

  int checks = 0;
  int errors = 0;

  mul_seq_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .mul_done     (mul_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int unsigned p;
    p = int'(a) * int'(b);
    return p[15:0];
  endfunction

  // Drive a one-cycle start; returns 1 ns after the accepting edge E0.
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    start = 1'b1; multiplicand = a; multiplier = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Edges after E0 until mul_done is seen high; -1 when the budget expires.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (mul_done) begin lat = k; return; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; multiplicand = 8'h00; multiplier = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (product !== 16'h0 || busy !== 1'b0 || mul_done !== 1'b0) begin
      errors++;
      $display("FAIL reset: product=%h busy=%b done=%b, want 0000 0 0", product, busy, mul_done);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int lat = -1;
    int ndone = 0;
    issue(8'h0F, 8'h0F);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_e0: busy=%b want 1", busy); end
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== (k <= 8)) begin
        errors++; $display("FAIL basic_busy_e%0d: busy=%b want %b", k, busy, (k <= 8));
      end
      checks++;
      if (mul_done !== (k == 8)) begin
        errors++; $display("FAIL basic_done_e%0d: done=%b want %b", k, mul_done, (k == 8));
      end
      if (mul_done) begin ndone++; lat = k; end
    end
    checks++;
    if (lat != 8 || ndone != 1) begin
      errors++; $display("FAIL basic_latency: lat=%0d pulses=%0d want 8 1", lat, ndone);
    end
    checks++;
    if (product !== 16'h00E1) begin errors++; $display("FAIL basic_product: %h want 00e1", product); end
  endtask

  task automatic test_max_operands;
    logic [7:0] av[2] = '{8'hFF, 8'h80};
    logic [7:0] bv[2] = '{8'hFF, 8'h02};
    logic [15:0] want[2] = '{16'hFE01, 16'h0100};
    int lat;
    for (int i = 0; i < 2; i++) begin
      issue(av[i], bv[i]);
      wait_done(lat);
      checks++;
      if (lat != 8 || product !== want[i]) begin
        errors++; $display("FAIL max_%0d: lat=%0d product=%h want 8 %h", i, lat, product, want[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_and_hold;
    int lat;
    issue(8'h00, 8'hAB);
    wait_done(lat);
    checks++;
    if (lat != 8 || product !== 16'h0000) begin
      errors++; $display("FAIL zero: lat=%0d product=%h want 8 0000", lat, product);
    end
    @(posedge clk); #1;
    issue(8'h0F, 8'h0F);
    multiplicand = 8'h55; multiplier = 8'hC3;
    wait_done(lat);
    checks++;
    if (lat != 8 || product !== ref_mul(8'h0F, 8'h0F)) begin
      errors++; $display("FAIL hold: lat=%0d product=%h want 8 00e1", lat, product);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_while_busy;
    int lat = -1;
    int ndone = 0;
    issue(8'h12, 8'h34);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 2) begin start = 1'b1; multiplicand = 8'h02; multiplier = 8'h02; end
      if (k == 3) start = 1'b0;
      if (mul_done) begin ndone++; if (lat < 0) lat = k; end
    end
    checks++;
    if (ndone != 1 || lat != 8) begin
      errors++; $display("FAIL busy_start_pulses: pulses=%0d lat=%0d want 1 8", ndone, lat);
    end
    checks++;
    if (product !== 16'h03A8) begin errors++; $display("FAIL busy_start_product: %h want 03a8", product); end
    issue(8'h02, 8'h02);
    wait_done(lat);
    checks++;
    if (lat != 8 || product !== 16'h0004) begin
      errors++; $display("FAIL busy_start_later: lat=%0d product=%h want 8 0004", lat, product);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int lat;
    int ndone = 0;
    issue(8'h03, 8'h05);
    wait_done(lat);
    checks++;
    if (lat != 8 || product !== 16'h000F) begin
      errors++; $display("FAIL rstmid_pre: lat=%0d product=%h want 8 000f", lat, product);
    end
    @(posedge clk); #1;
    issue(8'h10, 8'h10);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if (product !== 16'h0 || busy !== 1'b0 || mul_done !== 1'b0) begin
      errors++; $display("FAIL rstmid_async: product=%h busy=%b done=%b want 0000 0 0", product, busy, mul_done);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (mul_done || busy) ndone++;
    end
    checks++;
    if (ndone != 0) begin errors++; $display("FAIL rstmid_no_done: active cycles=%0d want 0", ndone); end
    issue(8'h07, 8'h09);
    wait_done(lat);
    checks++;
    if (lat != 8 || product !== 16'h003F) begin
      errors++; $display("FAIL rstmid_post: lat=%0d product=%h want 8 003f", lat, product);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [7:0]  a, b;
    logic [15:0] prev;
    int lat;
    int unstable;
    prev = product;
    for (int i = 0; i < 16; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      if (i == 0) begin a = 8'hFF; b = 8'hFE; end
      issue(a, b);
      unstable = 0;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk); #1;
        if (mul_done) begin lat = k; break; end
        if (product !== prev) unstable++;
      end
      checks++;
      if (lat != 8 || unstable != 0 || product !== ref_mul(a, b)) begin
        errors++;
        $display("FAIL b2b_%0d: %h*%h lat=%0d unstable=%0d product=%h want 8 0 %h",
                 i, a, b, lat, unstable, product, ref_mul(a, b));
      end
      prev = ref_mul(a, b);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_operands();
    test_zero_and_hold();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_seq_responder.md
Name: mul_seq_responder

Overview:
- Sequential shift-add unsigned multiplier; it is the responder side of the ALU's multiply start/done handshake.
- The ALU issues a one-cycle start pulse with operands on its data paths. This block latches the operands, iterates one bit per clock, and returns a 2*word_size product with a one-cycle mul_done pulse.
- The ALU consumes the result as two bytes, product[7:0] and product[15:8].

Parameters:
- word_size, 8, operand width in bits; the product is 2*word_size bits.
- cnt_size, 3, iteration counter width; must equal clog2(word_size).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request pulse from the ALU multiply sequencer.
- multiplicand  input  word_size  operand A; sampled only on the edge that accepts start.
- multiplier  input  word_size  operand B; sampled only on the edge that accepts start.
- product  output  2*word_size  unsigned A*B; registered; held until the next result.
- mul_done  output  1  registered one-cycle pulse marking product valid.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset:
  - While rst_n=0, asynchronously force state=IDLE, product=0, mul_done=0, busy=0, counter=0 and internal accumulator/operand registers=0.
  - Reset mid-operation aborts the multiply; no mul_done is issued for the aborted request.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a rising edge is accepted at that edge (E0).
  - Latch mcand_r=multiplicand, and load {acc_hi, acc_lo}={0, multiplier}, carry=0, counter=0; go to RUN.
  - start=0: remain in IDLE.
- RUN, one iteration per edge E1..E(word_size):
  - If acc_lo[0]=1, {carry, acc_hi} = acc_hi + mcand_r (word_size+1-bit sum); otherwise carry=0 and acc_hi is unchanged.
  - Then shift {carry, acc_hi, acc_lo} right by one.
  - counter increments each iteration.
  - On the iteration where counter=word_size-1 (edge E8 for the default), register product to the final {acc_hi, acc_lo} and go to DONE.
- DONE:
  - mul_done=1 for exactly this one cycle, E8 to E9 for the default; next edge returns to IDLE.
- Latency: mul_done is high in the cycle beginning word_size edges after the accepting edge. The default is 8 cycles, fixed and independent of operand values; there is no early exit on zero operands.
- product:
  - Changes only on entry to DONE or on reset.
  - Holds the previous result during RUN and afterwards until the next completion.
- start while RUN or DONE: ignored, with no restart and no queuing. The ALU also suppresses re-issue until mul_done.
- Operand changes after E0 have no effect; the ALU data paths are combinational and may move.
- start and rst_n low together: reset wins.
- Arithmetic:
  - Unsigned only; no overflow is possible in 2*word_size bits.
  - 0xFF*0xFF=0xFE01 must be exact, so the carry bit must be retained in each add.
- busy = (state != IDLE), driven from state registers (no combinational path from start).

Decomposition:
- Shared package mul_pkg:
  - state encoding constants ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10;
  - WORD_SIZE default;
  - localparam for the last-iteration count value.
  - The ALU-side sequencer imports the same package.
- One combinational sub-module is natural: mul_add_shift_stage.
  - Inputs: acc_hi, acc_lo, mcand.
  - Outputs: next acc_hi, next acc_lo.
  - The FSM, counter and output registers stay in the top module.

Test Plan:
- Basic multiply: reset, then start with multiplicand=0x0F, multiplier=0x0F -> after 8 cycles, mul_done pulses for 1 cycle; product=0x00E1; busy high for the 9 cycles E0..E9.
- Maximum operands: start with 0xFF, 0xFF -> product=0xFE01, checking carry retention. Then start with 0x80, 0x02 -> 0x0100.
- Zero operand and operand hold:
  - Start with 0x00, 0xAB -> product=0x0000 with the full 8-cycle latency.
  - Change multiplicand to 0x55 at E1 -> result unaffected.
- start while busy: start with 0x12, 0x34, then pulse start again at E3 with 0x02, 0x02 -> only one mul_done; product=0x03A8. A later start in IDLE with 0x02, 0x02 -> 0x0004.
- Reset mid-operation:
  - Complete 0x03*0x05=0x000F.
  - Start 0x10*0x10, then assert rst_n=0 at E4 -> product=0, busy=0 immediately, and no mul_done after release.
  - A new start with 0x07, 0x09 -> 0x003F.
- Back-to-back requests: issue start in the first IDLE cycle after each mul_done, 16 random operand pairs -> each product matches the A*B reference model. product stays stable between completions.
